ram4_bank: RTL and testbench



---
 rtl/ram4_bank_if.sv | 28 ++
 rtl/ram4_bank.sv | 82 ++++++++
 tb/tb_ram4_bank.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ram4_bank_if.sv
// ram4_bank_if: write/read bus between a host and the four-word register bank.
`default_nettype none

interface ram4_bank_if #(
   parameter int WIDTH = 16
);
   logic             load;
   logic [1:0]       addr;
   logic [WIDTH-1:0] in;
   logic             clear;
   logic [1:0]       raddr;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic [3:0]       word_valid;
   logic [7:0]       wr_count;

   modport master (
      output load, addr, in, clear, raddr,
      input  out, out_valid, word_valid, wr_count
   );

   modport slave (
      input  load, addr, in, clear, raddr,
      output out, out_valid, word_valid, wr_count
   );
endinterface

`default_nettype wire

// File: rtl/ram4_bank.sv
//------------------------------------------------------------------------------
// ram4_bank: four-word register bank, dmux4way write decode, registered read.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ram4_bank #(
   parameter int WIDTH = 16
) (
   input  wire logic   clk,
   input  wire logic   rst,
   ram4_bank_if.slave  bus
);

   logic [3:0]       load_dec;
   logic [WIDTH-1:0] mem_q [4];
   logic [WIDTH-1:0] mem_d [4];
   logic [3:0]       valid_q, valid_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             out_valid_q, out_valid_d;

   // dmux4way: the single load strobe steered to one word by addr
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_dmux
         assign load_dec[gi] = bus.load & (bus.addr == 2'(gi));
      end
   endgenerate

   always_comb begin
      mem_d       = mem_q;
      valid_d     = valid_q;
      cnt_d       = cnt_q;
      out_d       = mem_q[bus.raddr];
      out_valid_d = valid_q[bus.raddr];
      if (bus.clear) begin
         for (int k = 0; k < 4; k++) mem_d[k] = '0;
         valid_d     = '0;
         cnt_d       = '0;
         out_d       = '0;
         out_valid_d = 1'b0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (load_dec[k]) begin
               mem_d[k]   = bus.in;
               valid_d[k] = 1'b1;
            end
         end
         if (|load_dec) cnt_d = cnt_q + 8'd1;
         // write-first bypass when the read hits the word being written
         if (load_dec[bus.raddr]) begin
            out_d       = bus.in;
            out_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) mem_q[k] <= '0;
         valid_q     <= '0;
         cnt_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         for (int k = 0; k < 4; k++) mem_q[k] <= mem_d[k];
         valid_q     <= valid_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.out        = out_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.word_valid = valid_q;
   assign bus.wr_count   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ram4_bank.sv
// tb_ram4_bank: table-driven vectors with an expected-result queue for ram4_bank.
`default_nettype none

module tb_ram4_bank;

   typedef struct {
      logic        rst;
      logic        load;
      logic        clear;
      logic [1:0]  addr;
      logic [1:0]  raddr;
      logic [15:0] din;
      logic [15:0] eout;
      logic        evalid;
      logic [3:0]  ewv;
      logic [7:0]  ecnt;
   } vec_t;

   typedef struct {
      int          idx;
      logic [15:0] eout;
      logic        evalid;
      logic [3:0]  ewv;
      logic [7:0]  ecnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   step_no = 0;
   vec_t vecs[$];
   exp_t sb[$];

   always #5 clk = ~clk;

   ram4_bank_if #(.WIDTH(16)) bus ();

   ram4_bank #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   function automatic vec_t mk(input logic r, input logic ld, input logic clr,
                               input logic [1:0] a, input logic [1:0] ra,
                               input logic [15:0] d, input logic [15:0] eo,
                               input logic ev, input logic [3:0] ew,
                               input logic [7:0] ec);
      vec_t v;
      v.rst = r; v.load = ld; v.clear = clr; v.addr = a; v.raddr = ra;
      v.din = d; v.eout = eo; v.evalid = ev; v.ewv = ew; v.ecnt = ec;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL step %0d %s: got %h expected %h", idx, nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      exp_t e;
      rst       = v.rst;
      bus.load  = v.load;
      bus.clear = v.clear;
      bus.addr  = v.addr;
      bus.raddr = v.raddr;
      bus.in    = v.din;
      e.idx = step_no; e.eout = v.eout; e.evalid = v.evalid;
      e.ewv = v.ewv;   e.ecnt = v.ecnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL step %0d scoreboard: got empty queue expected entry", step_no);
      end else begin
         e = sb.pop_front();
         chk("out",        e.idx, 32'(bus.out),        32'(e.eout));
         chk("out_valid",  e.idx, 32'(bus.out_valid),  32'(e.evalid));
         chk("word_valid", e.idx, 32'(bus.word_valid), 32'(e.ewv));
         chk("wr_count",   e.idx, 32'(bus.wr_count),   32'(e.ecnt));
      end
      step_no++;
   endtask

   initial begin
      bus.load = 1'b0; bus.clear = 1'b0; bus.addr = 2'd0;
      bus.raddr = 2'd0; bus.in = 16'h0;

      //            rst  ld   clr  addr raddr din       out       ov   wv       cnt
      vecs.push_back(mk(1'b1,1'b1,1'b0,2'd0,2'd0,16'hFFFF,16'h0000,1'b0,4'b0000,8'd0));
      vecs.push_back(mk(1'b1,1'b1,1'b0,2'd0,2'd0,16'hFFFF,16'h0000,1'b0,4'b0000,8'd0));
      vecs.push_back(mk(1'b0,1'b1,1'b0,2'd0,2'd3,16'h0011,16'h0000,1'b0,4'b0001,8'd1));
      vecs.push_back(mk(1'b0,1'b1,1'b0,2'd1,2'd0,16'h0022,16'h0011,1'b1,4'b0011,8'd2));
      vecs.push_back(mk(1'b0,1'b1,1'b0,2'd2,2'd1,16'h0033,16'h0022,1'b1,4'b0111,8'd3));
      vecs.push_back(mk(1'b0,1'b1,1'b0,2'd3,2'd2,16'h0044,16'h0033,1'b1,4'b1111,8'd4));
      vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,2'd3,16'hAAAA,16'h0044,1'b1,4'b1111,8'd4));
      vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,2'd0,16'hAAAA,16'h0011,1'b1,4'b1111,8'd4));
      vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,2'd1,16'hAAAA,16'h0022,1'b1,4'b1111,8'd4));
      vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,2'd2,16'hAAAA,16'h0033,1'b1,4'b1111,8'd4));
      // same-edge write and read of word 2: write-first bypass
      vecs.push_back(mk(1'b0,1'b1,1'b0,2'd2,2'd2,16'hBEEF,16'hBEEF,1'b1,4'b1111,8'd5));
      vecs.push_back(mk(1'b0,1'b0,1'b0,2'd2,2'd1,16'h0000,16'h0022,1'b1,4'b1111,8'd5));
      vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,2'd2,16'h0000,16'hBEEF,1'b1,4'b1111,8'd5));
      vecs.push_back(mk(1'b0,1'b1,1'b0,2'd0,2'd1,16'h5555,16'h0022,1'b1,4'b1111,8'd6));
      vecs.push_back(mk(1'b0,1'b0,1'b0,2'd1,2'd0,16'h0000,16'h5555,1'b1,4'b1111,8'd6));
      // clear beats a coincident load
      vecs.push_back(mk(1'b0,1'b1,1'b1,2'd3,2'd0,16'h1234,16'h0000,1'b0,4'b0000,8'd0));
      vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,2'd3,16'h0000,16'h0000,1'b0,4'b0000,8'd0));
      vecs.push_back(mk(1'b0,1'b1,1'b0,2'd1,2'd0,16'h00A1,16'h0000,1'b0,4'b0010,8'd1));
      vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,2'd1,16'h0000,16'h00A1,1'b1,4'b0010,8'd1));
      vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,2'd0,16'h0000,16'h0000,1'b0,4'b0010,8'd1));
      // reset mid-operation discards the coincident load
      vecs.push_back(mk(1'b1,1'b1,1'b0,2'd2,2'd1,16'h7777,16'h0000,1'b0,4'b0000,8'd0));
      vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,2'd2,16'h0000,16'h0000,1'b0,4'b0000,8'd0));
      vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,2'd1,16'h0000,16'h0000,1'b0,4'b0000,8'd0));

      foreach (vecs[i]) apply(vecs[i]);

      // counter wrap: 257 writes to word 0, expected count tracked here
      begin
         int          cnt_m;
         logic [15:0] last;
         cnt_m = 0;
         last  = 16'h0;
         for (int i = 0; i < 257; i++) begin
            cnt_m = (cnt_m + 1) % 256;
            last  = 16'(i) ^ 16'hC300;
            apply(mk(1'b0, 1'b1, 1'b0, 2'd0, 2'd1, last, 16'h0000, 1'b0,
                     4'b0001, 8'(cnt_m)));
            if (i == 255) chk("wrap_to_zero", step_no, 32'(bus.wr_count), 32'd0);
         end
         chk("wrap_then_one", step_no, 32'(bus.wr_count), 32'd1);
         apply(mk(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 16'h0000, last, 1'b1,
                  4'b0001, 8'd1));
      end

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
